// File: rtl/jk_counter_reg_if.sv
// Bus bundle for jk_counter_reg: control/data toward the register and its state/flags back.
`timescale 1ns/1ps
interface jk_counter_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             En;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] D;
  logic             Clr_ovf;
  logic [WIDTH-1:0] Q;
  logic             Tc;
  logic             Wrap;
  logic             Ovf;

  modport master (
    output En, Mode, J, K, D, Clr_ovf,
    input  Q, Tc, Wrap, Ovf
  );

  modport slave (
    input  En, Mode, J, K, D, Clr_ovf,
    output Q, Tc, Wrap, Ovf
  );
endinterface

// File: rtl/jk_counter_reg.sv
// Multi-bit JK register: per-bit JK, toggle-chain up/down count, parallel load,
// combinational terminal count, registered wrap pulse and sticky overflow.
`timescale 1ns/1ps
module jk_counter_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic           Clk,
  input  logic           Rst_n,
  jk_counter_reg_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_UP = 2'b01,
    MODE_DN = 2'b10,
    MODE_LD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] up_t, dn_t;
  logic             tc;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  assign mode = mode_e'(bus.Mode);

  // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign up_t[i] = up_t[i-1] & q_q[i-1];
    assign dn_t[i] = dn_t[i-1] & ~q_q[i-1];
  end

  always_comb begin
    q_d = q_q;
    if (bus.En) begin
      unique case (mode)
        MODE_JK: begin
          for (int i = 0; i < WIDTH; i++) begin
            case ({bus.J[i], bus.K[i]})
              2'b01:   q_d[i] = 1'b0;
              2'b10:   q_d[i] = 1'b1;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
        end
        MODE_UP: q_d = q_q ^ up_t;
        MODE_DN: q_d = q_q ^ dn_t;
        MODE_LD: q_d = bus.D;
      endcase
    end
  end

  always_comb begin
    tc = 1'b0;
    unique case (mode)
      MODE_UP: tc = &q_q;
      MODE_DN: tc = ~|q_q;
      default: tc = 1'b0;
    endcase
  end

  // A set on the same edge as a clear keeps the flag high.
  assign wrap_d = bus.En & tc;
  assign ovf_d  = wrap_d | (ovf_q & ~bus.Clr_ovf);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Tc   = tc;
  assign bus.Wrap = wrap_q;
  assign bus.Ovf  = ovf_q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Directed checks on a 4-bit instance plus a model-checked random run on an 8-bit instance.
`timescale 1ns/1ps
module tb_jk_counter_reg;

  logic Clk;
  logic Rst_n;
  int   n_chk;
  int   n_pass;

  jk_counter_reg_if #(.WIDTH(4)) if4 ();
  jk_counter_reg_if #(.WIDTH(8)) if8 ();

  jk_counter_reg #(.WIDTH(4), .RST_VAL(32'hA)) dut4 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (if4.slave)
  );

  jk_counter_reg #(.WIDTH(8), .RST_VAL(32'h3C)) dut8 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (if8.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic expect4(input string tag, input logic [3:0] q, input logic tc,
                         input logic wrap, input logic ovf);
    chk({tag, ".q"},    32'(if4.Q),    32'(q));
    chk({tag, ".tc"},   32'(if4.Tc),   32'(tc));
    chk({tag, ".wrap"}, 32'(if4.Wrap), 32'(wrap));
    chk({tag, ".ovf"},  32'(if4.Ovf),  32'(ovf));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] m_q, m_d, m_j, m_k;
  logic       m_tc, m_wrap, m_ovf, m_en, m_clr;
  logic [1:0] m_mode;

  initial begin
    n_chk = 0;
    n_pass = 0;
    Rst_n = 1'b1;
    if4.En = 1'b0; if4.Mode = 2'b00; if4.J = '0; if4.K = '0; if4.D = '0; if4.Clr_ovf = 1'b0;
    if8.En = 1'b0; if8.Mode = 2'b00; if8.J = '0; if8.K = '0; if8.D = '0; if8.Clr_ovf = 1'b0;

    #2 Rst_n = 1'b0;
    #1;
    expect4("rst", 4'hA, 1'b0, 1'b0, 1'b0);
    chk("rst8.q", 32'(if8.Q), 32'h3C);
    #4 Rst_n = 1'b1;

    // JK: bit3 toggle, bit2 set, bit1 clear, bit0 hold, from 1010
    if4.En = 1'b1; if4.Mode = 2'b00; if4.J = 4'b1100; if4.K = 4'b1010;
    step();
    expect4("jk", 4'b0100, 1'b0, 1'b0, 1'b0);

    if4.Mode = 2'b11; if4.D = 4'hE;
    step();
    expect4("ld_e", 4'hE, 1'b0, 1'b0, 1'b0);
    if4.Mode = 2'b01;
    #1 chk("up_e.tc", 32'(if4.Tc), 32'h0);
    step(); expect4("up_f", 4'hF, 1'b1, 1'b0, 1'b0);
    step(); expect4("up_0", 4'h0, 1'b0, 1'b1, 1'b1);
    step(); expect4("up_1", 4'h1, 1'b0, 1'b0, 1'b1);

    if4.Mode = 2'b11; if4.D = 4'h1;
    step(); expect4("ld_1", 4'h1, 1'b0, 1'b0, 1'b1);
    if4.Mode = 2'b10;
    step(); expect4("dn_0", 4'h0, 1'b1, 1'b0, 1'b1);
    if4.Clr_ovf = 1'b1;
    step(); expect4("dn_coll", 4'hF, 1'b0, 1'b1, 1'b1);
    step(); expect4("dn_clr", 4'hE, 1'b0, 1'b0, 1'b0);
    if4.Clr_ovf = 1'b0;

    if4.Mode = 2'b11; if4.D = 4'hF;
    step(); expect4("ld_f", 4'hF, 1'b0, 1'b0, 1'b0);
    if4.Mode = 2'b01; if4.En = 1'b0;
    #1 chk("ld_up.tc", 32'(if4.Tc), 32'h1);
    repeat (3) begin
      step(); expect4("hold", 4'hF, 1'b1, 1'b0, 1'b0);
    end
    if4.En = 1'b1;
    step(); expect4("hold_rel", 4'h0, 1'b0, 1'b1, 1'b1);
    step(); expect4("hold_after", 4'h1, 1'b0, 1'b0, 1'b1);

    if4.Mode = 2'b11; if4.D = 4'h6;
    step(); expect4("ld_6", 4'h6, 1'b0, 1'b0, 1'b1);
    if4.Mode = 2'b01;
    step(); expect4("up_7", 4'h7, 1'b0, 1'b0, 1'b1);
    #3 Rst_n = 1'b0;
    #1 expect4("rst_mid", 4'hA, 1'b0, 1'b0, 1'b0);
    #1 Rst_n = 1'b1;
    step(); expect4("resume_b", 4'hB, 1'b0, 1'b0, 1'b0);
    step(); expect4("resume_c", 4'hC, 1'b0, 1'b0, 1'b0);

    if4.Mode = 2'b11; if4.D = 4'hF;
    step();
    if4.Mode = 2'b01;
    step(); expect4("pre_rst_wrap", 4'h0, 1'b0, 1'b1, 1'b1);
    #3 Rst_n = 1'b0;
    #1 expect4("rst_wrap", 4'hA, 1'b0, 1'b0, 1'b0);
    #1 Rst_n = 1'b1;
    if4.En = 1'b0;

    // Random run on the 8-bit instance, idle and freshly reset up to here.
    m_q = 8'h3C; m_ovf = 1'b0;
    chk("r8_start.q", 32'(if8.Q), 32'(m_q));
    for (int n = 0; n < 3000; n++) begin
      m_mode = 2'($urandom_range(3));
      m_en   = ($urandom_range(3) != 0);
      m_clr  = ($urandom_range(7) == 0);
      m_j    = 8'($urandom);
      m_k    = 8'($urandom);
      case ($urandom_range(5))
        0:       m_d = 8'hFF;
        1:       m_d = 8'h00;
        2:       m_d = 8'hFE;
        3:       m_d = 8'h01;
        default: m_d = 8'($urandom);
      endcase
      if8.Mode = m_mode; if8.En = m_en; if8.Clr_ovf = m_clr;
      if8.J = m_j; if8.K = m_k; if8.D = m_d;
      m_tc = (m_mode == 2'b01 && m_q == 8'hFF) || (m_mode == 2'b10 && m_q == 8'h00);
      #1 chk("r8.tc", 32'(if8.Tc), 32'(m_tc));
      step();
      if (m_en) begin
        case (m_mode)
          2'b00:   m_q = (m_j & ~m_q) | (~m_k & m_q);
          2'b01:   m_q = m_q + 8'd1;
          2'b10:   m_q = m_q - 8'd1;
          default: m_q = m_d;
        endcase
      end
      m_wrap = m_en & m_tc;
      m_ovf  = m_wrap | (m_ovf & ~m_clr);
      chk("r8.q",    32'(if8.Q),    32'(m_q));
      chk("r8.wrap", 32'(if8.Wrap), 32'(m_wrap));
      chk("r8.ovf",  32'(if8.Ovf),  32'(m_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
